// File: rtl/imem_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | imem_pkg : shared types and sizes for the instruction memory load/fetch   |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
package imem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } imem_ld_state_t;

    localparam int BYTES_PER_WORD     = 4;
    localparam int IMEM_BYTES_DEFAULT = 512;

    // Big-endian lane select: lane 0 is the most significant byte.
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | imem_loader : writes 32-bit host words into byte-wide instruction memory  |
// |               as four big-endian byte writes at consecutive addresses.    |
// | Revision    : 1.0                                                         |
// +---------------------------------------------------------------------------+
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES_DEFAULT,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic             word_valid,
    input  logic [31:0]      word_data,
    input  logic             word_last,
    output logic             word_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [7:0]       wr_byte,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - BYTES_PER_WORD);

    imem_ld_state_t   state_q, state_d;
    logic [31:0]      ptr_q, ptr_d;
    logic [31:0]      word_q, word_d;
    logic             last_q, last_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Word alignment is enforced by dropping the low address bits.
    logic unused_base_lsbs;
    assign unused_base_lsbs = ^base_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            bcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    ptr_d   = {base_addr[31:2], 2'b00};
                    cnt_d   = '0;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (word_valid) begin
                    word_d  = word_data;
                    last_d  = word_last;
                    bcnt_d  = '0;
                    // A word starting past the last full slot would run off the memory.
                    state_d = (ptr_q > LAST_WORD_ADDR) ? ST_ERR : ST_WRITE;
                end
            end
            ST_WRITE: begin
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    ptr_d   = ptr_q + 32'd4;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_q ? ST_DONE : ST_ACCEPT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word_ready = (state_q == ST_ACCEPT);
        wr_en      = (state_q == ST_WRITE);
        busy       = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
        done       = (state_q == ST_DONE);
        err        = (state_q == ST_ERR);
        word_count = cnt_q;
        wr_addr    = '0;
        wr_byte    = '0;
        if (state_q == ST_WRITE) begin
            wr_addr = ptr_q + {30'd0, bcnt_q};
            wr_byte = be_byte(word_q, bcnt_q);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_imem_loader : directed self-checking bench for imem_loader             |
// | Revision       : 1.0                                                      |
// +---------------------------------------------------------------------------+
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_byte;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] log_addr[$];
    logic [7:0]  log_byte[$];
    logic [7:0]  mem [0:511];

    imem_loader #(.MEM_BYTES(512), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(word_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_byte(wr_byte),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Memory model: captures every byte write like the real byte-wide memory.
    always @(posedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_byte.push_back(wr_byte);
            mem[wr_addr[8:0]] <= wr_byte;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        log_addr.delete();
        log_byte.delete();
    endtask

    task automatic do_start(input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int waited = 0;
        word_valid = 1'b1; word_data = d; word_last = l;
        while (word_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (word_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_timeout: word_ready=%b required 1", word_ready);
        end
        @(negedge clk);
        word_valid = 1'b0; word_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0;
        word_valid = 1'b0; word_data = '0; word_last = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({word_ready, wr_en, busy, done, err} !== 5'b0 || wr_addr !== 32'd0 ||
            wr_byte !== 8'd0 || word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/wen/busy/done/err=%b addr=%h byte=%h cnt=%0d required all 0",
                     {word_ready, wr_en, busy, done, err}, wr_addr, wr_byte, word_count);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (word_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: word_ready=%b busy=%b required 0 0", word_ready, busy);
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] exp_b [8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h06};
        logic [31:0] rd0, rd4;
        clear_log();
        do_start(32'd0);
        send_word(32'h20010005, 1'b0);
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 32'd0 || wr_byte !== 8'h20) begin
            n_fail++;
            $display("FAIL basic_first_write: wr_en=%b addr=%h byte=%h required 1 0 20", wr_en, wr_addr, wr_byte);
        end
        send_word(32'h20020006, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || word_count !== 16'd2) begin
            n_fail++;
            $display("FAIL basic_done: done=%b err=%b busy=%b cnt=%0d required 1 0 0 2", done, err, busy, word_count);
        end
        n_checks++;
        if (log_addr.size() != 8) begin
            n_fail++;
            $display("FAIL basic_write_count: writes=%0d required 8", log_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (log_addr[i] !== 32'(i) || log_byte[i] !== exp_b[i]) begin
                    n_fail++;
                    $display("FAIL basic_byte%0d: addr=%h byte=%h required %h %h",
                             i, log_addr[i], log_byte[i], i, exp_b[i]);
                end
            end
        end
        rd0 = {mem[0], mem[1], mem[2], mem[3]};
        rd4 = {mem[4], mem[5], mem[6], mem[7]};
        n_checks++;
        if (rd0 !== 32'h20010005 || rd4 !== 32'h20020006) begin
            n_fail++;
            $display("FAIL basic_fetch_readback: pc0=%h pc4=%h required 20010005 20020006", rd0, rd4);
        end
    endtask

    task automatic test_overflow();
        clear_log();
        do_start(32'd508);
        send_word(32'h01234567, 1'b0);
        send_word(32'h89ABCDEF, 1'b0);
        n_checks++;
        if (err !== 1'b1 || done !== 1'b0 || word_count !== 16'd1 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_state: err=%b done=%b cnt=%0d wr_en=%b required 1 0 1 0", err, done, word_count, wr_en);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (log_addr.size() != 4 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_writes: writes=%0d err=%b required 4 1", log_addr.size(), err);
        end else begin
            n_checks++;
            if (log_addr[0] !== 32'd508 || log_addr[3] !== 32'd511 || log_byte[0] !== 8'h01 || log_byte[3] !== 8'h67) begin
                n_fail++;
                $display("FAIL overflow_last_slot: a0=%0d a3=%0d b0=%h b3=%h required 508 511 01 67",
                         log_addr[0], log_addr[3], log_byte[0], log_byte[3]);
            end
        end
    endtask

    task automatic test_unaligned_base();
        clear_log();
        do_start(32'h06);
        send_word(32'hA1B2C3D4, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0 || word_count !== 16'd1 || log_addr.size() != 4) begin
            n_fail++;
            $display("FAIL unaligned_done: done=%b err=%b cnt=%0d writes=%0d required 1 0 1 4",
                     done, err, word_count, log_addr.size());
        end else begin
            n_checks++;
            if (log_addr[0] !== 32'd4 || log_addr[3] !== 32'd7 || log_byte[0] !== 8'hA1 || log_byte[3] !== 8'hD4) begin
                n_fail++;
                $display("FAIL unaligned_addr: a0=%0d a3=%0d b0=%h b3=%h required 4 7 a1 d4",
                         log_addr[0], log_addr[3], log_byte[0], log_byte[3]);
            end
        end
    endtask

    task automatic test_stall();
        clear_log();
        do_start(32'd0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (word_ready !== 1'b1 || wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: word_ready=%b wr_en=%b required 1 0", i, word_ready, wr_en);
            end
            @(negedge clk);
        end
        send_word(32'h5A5A1234, 1'b1);
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 32'd0 || wr_byte !== 8'h5A || log_addr.size() != 0) begin
            n_fail++;
            $display("FAIL stall_first_write: wr_en=%b addr=%h byte=%h prior_writes=%0d required 1 0 5a 0",
                     wr_en, wr_addr, wr_byte, log_addr.size());
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: done=%b required 1", done);
        end
    endtask

    task automatic test_start_during_write();
        logic [7:0] exp_b [4] = '{8'h00, 8'h22, 8'h18, 8'h20};
        clear_log();
        do_start(32'd16);
        send_word(32'h00221820, 1'b0);
        start = 1'b1; base_addr = 32'h100;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (word_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || word_count !== 16'd1 || log_addr.size() != 4) begin
            n_fail++;
            $display("FAIL start_ignored_state: rdy=%b busy=%b done=%b cnt=%0d writes=%0d required 1 1 0 1 4",
                     word_ready, busy, done, word_count, log_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (log_addr[i] !== 32'(16 + i) || log_byte[i] !== exp_b[i]) begin
                    n_fail++;
                    $display("FAIL start_ignored_byte%0d: addr=%0d byte=%h required %0d %h",
                             i, log_addr[i], log_byte[i], 16 + i, exp_b[i]);
                end
            end
        end
        send_word(32'hCAFEF00D, 1'b1);
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 32'd20 || wr_byte !== 8'hCA) begin
            n_fail++;
            $display("FAIL start_ignored_ptr: wr_en=%b addr=%0d byte=%h required 1 20 ca", wr_en, wr_addr, wr_byte);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        clear_log();
        do_start(32'd0);
        send_word(32'h11223344, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({word_ready, wr_en, busy, done, err} !== 5'b0 || wr_addr !== 32'd0 ||
            wr_byte !== 8'd0 || word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: rdy/wen/busy/done/err=%b addr=%h byte=%h cnt=%0d required all 0",
                     {word_ready, wr_en, busy, done, err}, wr_addr, wr_byte, word_count);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (word_ready !== 1'b0 || busy !== 1'b0 || word_count !== 16'd0) begin
                n_fail++;
                $display("FAIL post_reset_idle%0d: rdy=%b busy=%b cnt=%0d required 0 0 0", i, word_ready, busy, word_count);
            end
        end
        n_checks++;
        if (log_addr.size() != 2) begin
            n_fail++;
            $display("FAIL reset_partial_writes: writes=%0d required 2", log_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_overflow();
        test_unaligned_base();
        test_stall();
        test_start_during_write();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Loads a program into the byte-wide instruction memory. Accepts 32-bit instruction words from the assembler/host side over a valid/ready handshake and writes each word as four big-endian byte writes at consecutive byte addresses, so byte `addr` holds bits [31:24]. It is the write-side counterpart of the instruction fetch path: a word loaded at address A is read back by fetch as {mem[A], mem[A+1], mem[A+2], mem[A+3]}.

## Interface
Parameters:
- `MEM_BYTES`, default 512: instruction memory size in bytes; must be a multiple of 4.
- `CNT_W`, default 16: width of `word_count`.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `start`, in, 1: begin a load session at `base_addr`; honoured only in IDLE, DONE or ERR.
- `base_addr`, in, 32: start byte address; bits [1:0] are forced to 0.
- `word_valid`, in, 1: host presents a word.
- `word_data`, in, 32: instruction word.
- `word_last`, in, 1: qualifies `word_data` as the final word of the session.
- `word_ready`, out, 1: loader accepts a word this cycle.
- `wr_en`, out, 1: byte write strobe to instruction memory.
- `wr_addr`, out, 32: byte address.
- `wr_byte`, out, 8: byte data.
- `busy`, out, 1: high in ACCEPT and WRITE.
- `done`, out, 1: session completed; held until the next `start`.
- `err`, out, 1: overflow abort; held until the next `start`.
- `word_count`, out, CNT_W: number of words fully written in the current session.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE, ERR. All outputs are Moore, decoded from registered state.
- IDLE, DONE, ERR: `word_ready` = 0. On `start`, set `ptr <= {base_addr[31:2], 2'b00}`, clear `word_count`, `done` and `err`, and go to ACCEPT.
- ACCEPT: `word_ready` = 1. On `word_valid`, capture `word_data` and `word_last`.
  - If `ptr > MEM_BYTES-4`, go to ERR. No byte is written.
  - Otherwise go to WRITE with `bcnt` = 0.
- WRITE: `wr_en` = 1, `wr_addr` = `ptr + bcnt`, `wr_byte` = `word[31-8*bcnt -: 8]`. `bcnt` increments each cycle.
  - When `bcnt` = 3: `ptr += 4` and `word_count += 1`.
  - Then go to DONE if the captured last flag is 1, else back to ACCEPT.
- `start` is ignored in ACCEPT and WRITE. `word_valid` is ignored outside ACCEPT.
- `word_count` wraps modulo 2^CNT_W. It cannot overflow for the default `MEM_BYTES`.
- The last usable word is at `MEM_BYTES-4`. Writing it is legal. Only the following word triggers ERR.

## Timing
- Reset values: state IDLE; `word_ready`, `wr_en`, `busy`, `done`, `err` = 0; `wr_addr`, `wr_byte`, `word_count`, `ptr` = 0.
- Handshake: a transfer occurs on the edge where `word_valid` and `word_ready` are both 1. The host must hold its data until that edge.
- A word accepted at edge k drives byte writes in cycles k+1 .. k+4.
- The next `word_ready` is asserted in cycle k+5, giving a peak throughput of 1 word per 5 cycles.
- `done` and `err` rise in the cycle after the last write cycle, or after the overflowing handshake.
- `start` and `word_valid` in the same cycle in IDLE: the word is not accepted, because `word_ready` was 0.
- Reset mid-WRITE: `wr_en` drops immediately, since reset is asynchronous.
  - Bytes already written stay in memory.
  - The partial word is not counted.
  - The host must restart with `start`.

## Structure
- Shared package `imem_pkg` holds:
  - the state enum `imem_ld_state_t`;
  - `BYTES_PER_WORD` = 4;
  - `IMEM_BYTES_DEFAULT` = 512, shared with the fetch-side memory.
- No sub-module. Byte-lane selection and address generation stay inline in `imem_loader`.

## Test plan
- `start`, `base_addr`=0; load 0x20010005 (last=0), then 0x20020006 (last=1).
  - Required: bytes 20,01,00,05 written to addresses 0–3, then 20,02,00,06 to addresses 4–7.
  - `done`=1, `word_count`=2. Readback via the fetch path at PC 0 and PC 4 returns the original words.
- `base_addr`=508; load two words.
  - Required: first word written to 508–511; second handshake produces no `wr_en`.
  - `err`=1, `done`=0, `word_count`=1.
- `base_addr`=0x06; one word, last=1.
  - Required: writes to addresses 4–7, `done`=1.
- Host holds `word_valid`=0 for 3 cycles in ACCEPT.
  - Required: `word_ready` stays 1, no `wr_en`; the first write occurs 1 cycle after `word_valid` rises.
- `start` pulsed during WRITE of word 0x00221820.
  - Required: ignored. All 4 bytes (00,22,18,20) are written and `ptr` advances by 4.
- `rst` asserted after the 2nd byte write.
  - Required: all outputs 0 in the same cycle; state IDLE; `word_count`=0; `word_ready` stays 0 until `start`.
